// File: rtl/operand_fetch_stage.sv
// Operand fetch: drives register-file reads, resolves operands, tracks pending writes, feeds execute.
// Macro OPERAND_FORWARD_EN enables the same-cycle writeback bypass; without it pending sources stall.
module operand_fetch_stage #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 5,
    parameter int NUM_REGS      = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    // Handshake: a transfer happens on a cycle where valid and ready are both high.
    input  logic                     id_valid,
    output logic                     id_ready,
    input  logic [ADDRESS_WIDTH-1:0] id_rs1,
    input  logic [ADDRESS_WIDTH-1:0] id_rs2,
    input  logic                     id_use_rs1,
    input  logic                     id_use_rs2,
    input  logic [ADDRESS_WIDTH-1:0] id_rd,
    input  logic                     id_reg_write,
    input  logic [DATA_WIDTH-1:0]    id_imm,
    input  logic [DATA_WIDTH-1:0]    id_pc,
    output logic [ADDRESS_WIDTH-1:0] rs1,
    output logic [ADDRESS_WIDTH-1:0] rs2,
    input  logic [DATA_WIDTH-1:0]    read_reg1,
    input  logic [DATA_WIDTH-1:0]    read_reg2,
    input  logic                     wb_reg_write,
    input  logic [ADDRESS_WIDTH-1:0] wb_rd,
    input  logic [DATA_WIDTH-1:0]    wb_data,
    output logic                     ex_valid,
    input  logic                     ex_ready,
    output logic [DATA_WIDTH-1:0]    ex_op1,
    output logic [DATA_WIDTH-1:0]    ex_op2,
    output logic [DATA_WIDTH-1:0]    ex_imm,
    output logic [DATA_WIDTH-1:0]    ex_pc,
    output logic [ADDRESS_WIDTH-1:0] ex_rd,
    output logic                     ex_reg_write,
    input  logic                     flush
);

    logic [NUM_REGS-1:0]      pending_q, pending_d;
    logic                     ex_valid_q;
    logic [DATA_WIDTH-1:0]    ex_op1_q, ex_op2_q, ex_imm_q, ex_pc_q;
    logic [ADDRESS_WIDTH-1:0] ex_rd_q;
    logic                     ex_reg_write_q;

    logic                     fwd1, fwd2, raw1, raw2, waw, space, issue;
    logic [DATA_WIDTH-1:0]    op1, op2;

    assign rs1 = id_rs1;
    assign rs2 = id_rs2;

`ifdef OPERAND_FORWARD_EN
    assign fwd1 = wb_reg_write && (wb_rd != '0) && (wb_rd == id_rs1);
    assign fwd2 = wb_reg_write && (wb_rd != '0) && (wb_rd == id_rs2);
`else
    assign fwd1 = 1'b0;
    assign fwd2 = 1'b0;
`endif

    assign raw1  = id_use_rs1 && (id_rs1 != '0) && pending_q[id_rs1] && !fwd1;
    assign raw2  = id_use_rs2 && (id_rs2 != '0) && pending_q[id_rs2] && !fwd2;
    // A writeback retiring the same rd this cycle frees the slot for the new writer.
    assign waw   = id_reg_write && (id_rd != '0) && pending_q[id_rd]
                   && !(wb_reg_write && (wb_rd == id_rd));
    assign space = !ex_valid_q || ex_ready;

    assign id_ready = !rst && !flush && space && !raw1 && !raw2 && !waw;
    assign issue    = id_valid && id_ready;

    assign op1 = (id_rs1 == '0) ? '0 : (fwd1 ? wb_data : read_reg1);
    assign op2 = (id_rs2 == '0) ? '0 : (fwd2 ? wb_data : read_reg2);

    // Clears first, then the issuing writer's set, so a set wins at the same index.
    always_comb begin
        pending_d = pending_q;
        if (wb_reg_write) pending_d[wb_rd] = 1'b0;
        if (flush && ex_valid_q && ex_reg_write_q && (ex_rd_q != '0)) pending_d[ex_rd_q] = 1'b0;
        if (issue && id_reg_write && (id_rd != '0)) pending_d[id_rd] = 1'b1;
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q      <= '0;
            ex_valid_q     <= 1'b0;
            ex_op1_q       <= '0;
            ex_op2_q       <= '0;
            ex_imm_q       <= '0;
            ex_pc_q        <= '0;
            ex_rd_q        <= '0;
            ex_reg_write_q <= 1'b0;
        end else begin
            pending_q <= pending_d;
            if (issue) begin
                ex_valid_q     <= 1'b1;
                ex_op1_q       <= op1;
                ex_op2_q       <= op2;
                ex_imm_q       <= id_imm;
                ex_pc_q        <= id_pc;
                ex_rd_q        <= id_rd;
                ex_reg_write_q <= id_reg_write;
            end else if (flush || ex_ready) begin
                ex_valid_q <= 1'b0;
            end
        end
    end

    assign ex_valid     = ex_valid_q;
    assign ex_op1       = ex_op1_q;
    assign ex_op2       = ex_op2_q;
    assign ex_imm       = ex_imm_q;
    assign ex_pc        = ex_pc_q;
    assign ex_rd        = ex_rd_q;
    assign ex_reg_write = ex_reg_write_q;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Testbench for operand_fetch_stage: directed scenarios then randomized traffic against a reference model.
// Follows OPERAND_FORWARD_EN the same way the design does.
module tb_operand_fetch_stage;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 32;
`ifdef OPERAND_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic          clk, rst;
    logic          id_valid, id_ready, id_use_rs1, id_use_rs2, id_reg_write;
    logic [AW-1:0] id_rs1, id_rs2, id_rd, rs1, rs2, wb_rd, ex_rd;
    logic [DW-1:0] id_imm, id_pc, read_reg1, read_reg2, wb_data;
    logic [DW-1:0] ex_op1, ex_op2, ex_imm, ex_pc;
    logic          wb_reg_write, ex_valid, ex_ready, ex_reg_write, flush;

    int checks = 0;
    int errors = 0;

    // Reference state: register file contents, pending set, and the instruction held for execute.
    logic [DW-1:0] rf[NR];
    logic [NR-1:0] m_pend = '0;
    logic          m_valid = 1'b0, m_rw = 1'b0;
    logic [DW-1:0] m_op1 = '0, m_op2 = '0, m_imm = '0, m_pc = '0;
    logic [AW-1:0] m_rd = '0;
    bit            last_issue;
    bit            stray_en = 1'b0;
    logic [DW-1:0] stray_val = '0;

    operand_fetch_stage dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_imm(id_imm), .id_pc(id_pc),
        .rs1(rs1), .rs2(rs2), .read_reg1(read_reg1), .read_reg2(read_reg2),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_imm(ex_imm), .ex_pc(ex_pc),
        .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .flush(flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit fh(input logic [AW-1:0] s);
        return FWD && wb_reg_write && (wb_rd != 0) && (wb_rd == s);
    endfunction

    // One clock: called at a negedge with inputs set, returns at the next negedge.
    task automatic tick();
        bit            r1, r2, w, exp_rdy, iss;
        logic [DW-1:0] o1, o2;
        read_reg1 = stray_en ? stray_val : rf[id_rs1];
        read_reg2 = rf[id_rs2];
        #1;
        r1 = id_use_rs1 && (id_rs1 != 0) && m_pend[id_rs1] && !fh(id_rs1);
        r2 = id_use_rs2 && (id_rs2 != 0) && m_pend[id_rs2] && !fh(id_rs2);
        w  = id_reg_write && (id_rd != 0) && m_pend[id_rd] && !(wb_reg_write && wb_rd == id_rd);
        exp_rdy = !rst && !flush && (!m_valid || ex_ready) && !r1 && !r2 && !w;
        iss = id_valid && exp_rdy;
        o1 = (id_rs1 == 0) ? '0 : (fh(id_rs1) ? wb_data : read_reg1);
        o2 = (id_rs2 == 0) ? '0 : (fh(id_rs2) ? wb_data : read_reg2);
        chk("id_ready", id_ready, exp_rdy);
        chk("rs1_addr", rs1, id_rs1);
        chk("rs2_addr", rs2, id_rs2);
        @(posedge clk);
        if (rst) begin
            m_pend = '0; m_valid = 0; m_rw = 0; m_rd = '0;
            m_op1 = '0; m_op2 = '0; m_imm = '0; m_pc = '0;
            iss = 0;
        end else begin
            if (wb_reg_write) m_pend[wb_rd] = 1'b0;
            if (flush && m_valid && m_rw && m_rd != 0) m_pend[m_rd] = 1'b0;
            if (iss) begin
                m_valid = 1; m_op1 = o1; m_op2 = o2; m_imm = id_imm; m_pc = id_pc;
                m_rd = id_rd; m_rw = id_reg_write;
                if (id_reg_write && id_rd != 0) m_pend[id_rd] = 1'b1;
            end else if (flush || ex_ready) begin
                m_valid = 0;
            end
        end
        if (wb_reg_write && wb_rd != 0) rf[wb_rd] = wb_data;
        last_issue = iss;
        @(negedge clk);
        chk("ex_valid", ex_valid, m_valid);
        chk("pending", dut.pending_q, m_pend);
        if (m_valid) begin
            chk("ex_op1", ex_op1, m_op1);
            chk("ex_op2", ex_op2, m_op2);
            chk("ex_imm", ex_imm, m_imm);
            chk("ex_pc", ex_pc, m_pc);
            chk("ex_rd", ex_rd, m_rd);
            chk("ex_reg_write", ex_reg_write, m_rw);
        end
    endtask

    task automatic set_id(input logic v, input logic [AW-1:0] a1, input logic u1,
                          input logic [AW-1:0] a2, input logic u2,
                          input logic [AW-1:0] d, input logic rw, input logic [DW-1:0] imm);
        id_valid = v; id_rs1 = a1; id_use_rs1 = u1; id_rs2 = a2; id_use_rs2 = u2;
        id_rd = d; id_reg_write = rw; id_imm = imm; id_pc = 32'h1000 + imm;
    endtask

    task automatic idle();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        wb_reg_write = 0; wb_rd = '0; wb_data = '0;
        flush = 0; ex_ready = 1; stray_en = 0;
    endtask

    initial begin
        for (int i = 0; i < NR; i++) rf[i] = (i == 0) ? '0 : 32'h100 * i;
        rf[3] = 32'h10;
        rst = 1;
        idle();
        @(negedge clk);
        tick();
        tick();
        chk("rst_ex_op1", ex_op1, 0);
        chk("rst_ex_pc", ex_pc, 0);
        chk("rst_ex_rd", ex_rd, 0);
        chk("rst_pending", dut.pending_q, 0);
        rst = 0;

        // ADDI x4, x3, 5
        set_id(1, 3, 1, 0, 0, 4, 1, 5);
        tick();
        chk("addi_op1", ex_op1, 32'h10);
        chk("addi_imm", ex_imm, 5);
        chk("addi_rd", ex_rd, 4);
        chk("addi_pend4", dut.pending_q[4], 1);
        idle();
        tick();

        // Reader of x4 while x4 is being written back
        set_id(1, 4, 1, 0, 0, 5, 0, 6);
        wb_reg_write = 1; wb_rd = 4; wb_data = 32'hABCD;
        tick();
        wb_reg_write = 0;
        if (!last_issue) tick();
        chk("bypass_op1", ex_op1, 32'hABCD);
        idle();
        tick();

        // Stall on pending x7 as rs2 until it is written back
        set_id(1, 0, 0, 0, 0, 7, 1, 7);
        tick();
        set_id(1, 1, 1, 7, 1, 0, 0, 8);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_rs2", id_ready, 0);
        end
        wb_reg_write = 1; wb_rd = 7; wb_data = 32'h55;
        tick();
        wb_reg_write = 0;
        if (!last_issue) tick();
        chk("stall_op2", ex_op2, 32'h55);
        idle();
        tick();

        // Back-pressure from execute
        set_id(1, 2, 1, 0, 0, 10, 1, 32'hA);
        tick();
        ex_ready = 0;
        set_id(1, 2, 1, 3, 1, 11, 1, 32'hB);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_hold_imm", ex_imm, 32'hA);
            chk("bp_ready", id_ready, 0);
        end
        ex_ready = 1;
        tick();
        chk("bp_next_imm", ex_imm, 32'hB);
        chk("bp_next_rd", ex_rd, 11);
        idle();
        tick();

        // Flush a held writer of x9, then a reader of x9 issues at once
        ex_ready = 0;
        set_id(1, 0, 0, 0, 0, 9, 1, 9);
        tick();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        flush = 1;
        tick();
        chk("flush_valid", ex_valid, 0);
        chk("flush_pend9", dut.pending_q[9], 0);
        flush = 0;
        set_id(1, 9, 1, 0, 0, 0, 0, 12);
        tick();
        chk("after_flush_issue", ex_valid, 1);
        idle();
        tick();

        // x0 source, x0 writeback and x0 destination
        set_id(1, 0, 1, 0, 0, 0, 1, 13);
        stray_en = 1; stray_val = 32'h1234;
        wb_reg_write = 1; wb_rd = 0; wb_data = 32'hFFFF;
        tick();
        chk("x0_op1", ex_op1, 0);
        chk("x0_pend0", dut.pending_q[0], 0);
        chk("x0_valid", ex_valid, 1);
        idle();
        tick();

        // Randomized traffic, including occasional reset and flush
        for (int n = 0; n < 500; n++) begin
            rst = ($urandom_range(0, 99) == 0);
            set_id($urandom_range(0, 3) != 0,
                   AW'($urandom_range(0, 7)), $urandom_range(0, 1) == 1,
                   AW'($urandom_range(0, 7)), $urandom_range(0, 1) == 1,
                   AW'($urandom_range(0, 7)), $urandom_range(0, 1) == 1,
                   $urandom);
            wb_reg_write = ($urandom_range(0, 2) == 0);
            wb_rd = AW'($urandom_range(0, 7));
            wb_data = $urandom;
            flush = ($urandom_range(0, 9) == 0);
            ex_ready = ($urandom_range(0, 3) != 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
